rob_commit_unit: RTL and testbench
==================================

Name: rob_commit_unit

Overview:
- Reorder buffer that receives in-order issue from the decoder and out-of-order results from the CDB.
- Retires entries in order to the register file through commit_ready / commit_reg_id / commit_val / commit_rob_id.
- Answers the register file's two combinational dependency lookups (search ports).
- Generates the pipeline-wide clear on a committed branch mispredict.

Parameters:
ROB_WIDTH, 4, tag width; depth DEPTH = 2**ROB_WIDTH entries

Ports:
clk_in  input  1  system clock
rst_n_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  pause when low: no state change, commit_ready forced 0
issue_valid  input  1  decoder issues one instruction this cycle
issue_rd  input  5  destination reg (0 = no destination)
issue_rob_id  output  ROB_WIDTH  tag allocated to the issuing instruction (= tail)
rob_full  output  1  no free entry; decoder must not issue
wb_valid  input  1  CDB result valid
wb_rob_id  input  ROB_WIDTH  CDB result tag
wb_val  input  32  CDB result value
wb_mispredict  input  1  result is a mispredicted branch
wb_target  input  32  correct PC when wb_mispredict=1
search_rob_id_1  input  ROB_WIDTH  lookup tag 1
search_ready_1  output  1  entry 1 has its value
search_val_1  output  32  value of entry 1 (0 if not ready)
search_rob_id_2  input  ROB_WIDTH  lookup tag 2
search_ready_2  output  1  entry 2 has its value
search_val_2  output  32  value of entry 2 (0 if not ready)
commit_ready  output  1  head retires this cycle
commit_reg_id  output  5  head destination reg
commit_val  output  32  head value
commit_rob_id  output  ROB_WIDTH  head tag
clear  output  1  one-cycle flush pulse to all units
clear_pc  output  32  redirect PC, valid while clear=1

Behaviour:
Storage
- Per entry: busy, ready, rd[4:0], val[31:0], mispredict, target[31:0].
- Pointers head and tail, each ROB_WIDTH bits; count, ROB_WIDTH+1 bits. Pointers wrap DEPTH-1 -> 0.

Reset (rst_n_in=0, asynchronous)
- head=tail=count=0; all busy/ready=0; clear=0; clear_pc=0.
- Consequently commit_ready=0, rob_full=0, search_ready_*=0.

Status and allocation
- rob_full = (count==DEPTH), from registered count only. A commit in the same cycle does not free a slot for issue.
- issue_rob_id = tail, always driven.

Issue
- Condition: issue_valid && !rob_full && rdy_in && !clear.
- Writes the tail entry: busy=1, ready=0, rd=issue_rd, mispredict=0. Then tail+1.
- issue_valid while full is ignored (no state change).

Writeback
- Condition: wb_valid && rdy_in && !clear && busy[wb_rob_id].
- Sets ready=1, val=wb_val, mispredict=wb_mispredict, target=wb_target.
- Writeback to a non-busy entry is ignored.

Commit
- Combinational: commit_ready = rdy_in && !clear && count!=0 && ready[head].
- commit_reg_id/commit_val/commit_rob_id show the head entry whenever count!=0, else 0.
- On the clock edge with commit_ready: busy[head]=0, head+1.

Count
- count +1 on issue only, -1 on commit only, unchanged when both or neither occur.

Mispredict flush
- Trigger: commit_ready && mispredict[head].
- The entry still commits (commit_ready=1 that cycle).
- At the edge: clear<=1, clear_pc<=target[head], and all busy/ready cleared, head=tail=count=0.
- clear is high exactly one cycle, then returns to 0.
- While clear=1: issue, writeback and commit are all ignored.

Search
- Purely combinational: search_ready_k = busy[id] && ready[id]; search_val_k = val[id] if ready, else 0.

Simultaneous events
- Writeback to the head entry in the same cycle does not commit that cycle; it commits next cycle.
- Issue into a slot freed by commit in the same cycle cannot occur, because of the rob_full rule.

rdy_in low
- All registers hold, including clear (a pending clear pulse is extended until rdy_in returns).

Optional Feature:
WB_BYPASS_EN
- Defined:
  - A search whose tag equals wb_rob_id while wb_valid && busy[wb_rob_id] returns ready=1, val=wb_val in the same cycle.
  - The head entry may commit in the same cycle as its writeback, with commit_val = wb_val.
  - wb_mispredict/wb_target are honoured for the flush in that case.
- Undefined: no bypass; behaviour exactly as in Behaviour.

Test Plan:
- Reset: assert rst_n_in mid-run with 5 entries busy -> outputs 0 immediately (async), count=0, issue_rob_id=0 after release.
- Fill/full:
  - Issue 16 instructions with ROB_WIDTH=4 -> rob_full=1 after the 16th.
  - A 17th issue is ignored, tail stays 0.
  - One commit -> rob_full=0 next cycle.
- Out-of-order writeback:
  - Issue rd=5,6,7 (tags 0,1,2); writeback tags 2 (val 0x33), 1 (0x22), then 0 (0x11).
  - Commits occur in tag order 0,1,2 on consecutive cycles, with vals 0x11, 0x22, 0x33.
- Search: tag 3 written back with 0xABCD -> search_ready_1=1, search_val_1=0xABCD; unwritten tag 4 -> ready=0, val=0.
- Mispredict:
  - Tag 1 written back with wb_mispredict=1, wb_target=0x100; tags 2–4 busy.
  - Tag 1 commits, then clear=1 with clear_pc=0x100 for one cycle.
  - Afterwards count=0 and issue_rob_id=0.
- Wrap/pause: cycle 40 instructions through; during commits drop rdy_in for 3 cycles -> no state change and commit_ready=0; pointers wrap 15->0 correctly.

Source files
------------

// File: rtl/rob_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : rob_commit_unit
// Purpose  : Reorder buffer. Accepts in-order issue from the decoder and
//            out-of-order results from the CDB, retires entries in order to
//            the register file, answers two dependency lookups, and raises a
//            one-cycle pipeline clear when a mispredicted branch retires.
// Ports    : clk_in, rst_n_in (async, active-low), rdy_in (pause)
//            issue_valid/issue_rd -> issue_rob_id, rob_full
//            wb_valid/wb_rob_id/wb_val/wb_mispredict/wb_target (CDB)
//            search_rob_id_k -> search_ready_k/search_val_k (k = 1,2)
//            commit_ready/commit_reg_id/commit_val/commit_rob_id
//            clear/clear_pc
// Options  : WB_BYPASS_EN - forward the CDB result to the search ports and
//            to the head entry in the same cycle as its writeback.
// Revision : 1.0 - initial release
// ============================================================================
module rob_commit_unit #(
   parameter int ROB_WIDTH = 4
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic                 rdy_in,
   input  logic                 issue_valid,
   input  logic [4:0]           issue_rd,
   output logic [ROB_WIDTH-1:0] issue_rob_id,
   output logic                 rob_full,
   input  logic                 wb_valid,
   input  logic [ROB_WIDTH-1:0] wb_rob_id,
   input  logic [31:0]          wb_val,
   input  logic                 wb_mispredict,
   input  logic [31:0]          wb_target,
   input  logic [ROB_WIDTH-1:0] search_rob_id_1,
   output logic                 search_ready_1,
   output logic [31:0]          search_val_1,
   input  logic [ROB_WIDTH-1:0] search_rob_id_2,
   output logic                 search_ready_2,
   output logic [31:0]          search_val_2,
   output logic                 commit_ready,
   output logic [4:0]           commit_reg_id,
   output logic [31:0]          commit_val,
   output logic [ROB_WIDTH-1:0] commit_rob_id,
   output logic                 clear,
   output logic [31:0]          clear_pc
);

   localparam int                 c_depth   = 2**ROB_WIDTH;
   localparam logic [ROB_WIDTH:0] c_full    = (ROB_WIDTH+1)'(c_depth);
   localparam logic [ROB_WIDTH:0] c_cnt_one = (ROB_WIDTH+1)'(1);
   localparam logic [ROB_WIDTH-1:0] c_ptr_one = ROB_WIDTH'(1);

   // Control state (asynchronously reset)
   logic [c_depth-1:0]   r_busy;
   logic [c_depth-1:0]   r_ready;
   logic [ROB_WIDTH-1:0] r_head;
   logic [ROB_WIDTH-1:0] r_tail;
   logic [ROB_WIDTH:0]   r_count;
   logic                 r_clear;
   logic [31:0]          r_clear_pc;

   // Payload (no reset needed: only observed once busy/ready are set)
   logic [4:0]  r_rd       [c_depth];
   logic [31:0] r_val      [c_depth];
   logic        r_mispred  [c_depth];
   logic [31:0] r_target   [c_depth];

   logic        w_nonempty;
   logic        w_issue;
   logic        w_wb;
   logic        w_head_byp;
   logic        w_head_ready;
   logic [31:0] w_head_val;
   logic        w_head_mispred;
   logic [31:0] w_head_target;
   logic        w_commit;
   logic        w_flush;
   logic        w_s1_byp;
   logic        w_s2_byp;

   assign w_nonempty = (r_count != '0);
   assign rob_full   = (r_count == c_full);
   assign issue_rob_id = r_tail;

   assign w_issue = issue_valid && !rob_full && rdy_in && !r_clear;
   assign w_wb    = wb_valid && rdy_in && !r_clear && r_busy[wb_rob_id];

`ifdef WB_BYPASS_EN
   // A result arriving for a busy entry is visible in the same cycle.
   assign w_head_byp = wb_valid && r_busy[wb_rob_id] && (wb_rob_id == r_head);
   assign w_s1_byp   = wb_valid && r_busy[wb_rob_id] && (wb_rob_id == search_rob_id_1);
   assign w_s2_byp   = wb_valid && r_busy[wb_rob_id] && (wb_rob_id == search_rob_id_2);
`else
   assign w_head_byp = 1'b0;
   assign w_s1_byp   = 1'b0;
   assign w_s2_byp   = 1'b0;
`endif

   // Head view: stored entry, or the CDB result when it is being bypassed
   // into a head that has not yet captured its value.
   always_comb begin
      w_head_ready   = r_ready[r_head] || w_head_byp;
      w_head_val     = r_val[r_head];
      w_head_mispred = r_mispred[r_head];
      w_head_target  = r_target[r_head];
      if (w_head_byp && !r_ready[r_head]) begin
         w_head_val     = wb_val;
         w_head_mispred = wb_mispredict;
         w_head_target  = wb_target;
      end
   end

   assign w_commit = rdy_in && !r_clear && w_nonempty && w_head_ready;
   assign w_flush  = w_commit && w_head_mispred;

   assign commit_ready  = w_commit;
   assign commit_reg_id = w_nonempty ? r_rd[r_head] : 5'd0;
   assign commit_val    = w_nonempty ? w_head_val   : 32'd0;
   assign commit_rob_id = w_nonempty ? r_head       : '0;

   assign clear    = r_clear;
   assign clear_pc = r_clear_pc;

   // Search ports
   assign search_ready_1 = (r_busy[search_rob_id_1] && r_ready[search_rob_id_1]) || w_s1_byp;
   assign search_ready_2 = (r_busy[search_rob_id_2] && r_ready[search_rob_id_2]) || w_s2_byp;
   assign search_val_1   = !search_ready_1 ? 32'd0 :
                           (w_s1_byp && !r_ready[search_rob_id_1]) ? wb_val : r_val[search_rob_id_1];
   assign search_val_2   = !search_ready_2 ? 32'd0 :
                           (w_s2_byp && !r_ready[search_rob_id_2]) ? wb_val : r_val[search_rob_id_2];

   // Control state
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_busy     <= '0;
         r_ready    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_count    <= '0;
         r_clear    <= 1'b0;
         r_clear_pc <= 32'd0;
      end else if (rdy_in) begin
         // clear is a single-cycle pulse; held only while rdy_in is low.
         r_clear <= w_flush;
         if (w_flush) begin
            r_clear_pc <= w_head_target;
            r_busy     <= '0;
            r_ready    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
         end else begin
            if (w_issue) begin
               r_busy[r_tail]  <= 1'b1;
               r_ready[r_tail] <= 1'b0;
               r_tail          <= r_tail + c_ptr_one;
            end
            if (w_wb) begin
               r_ready[wb_rob_id] <= 1'b1;
            end
            if (w_commit) begin
               r_busy[r_head] <= 1'b0;
               r_head         <= r_head + c_ptr_one;
            end
            case ({w_issue, w_commit})
               2'b10:   r_count <= r_count + c_cnt_one;
               2'b01:   r_count <= r_count - c_cnt_one;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   // Payload. Issue targets a non-busy slot and writeback a busy one, so
   // the two never address the same entry in one cycle.
   always_ff @(posedge clk_in) begin
      if (w_issue) begin
         r_rd[r_tail]      <= issue_rd;
         r_mispred[r_tail] <= 1'b0;
      end
      if (w_wb) begin
         r_val[wb_rob_id]     <= wb_val;
         r_mispred[wb_rob_id] <= wb_mispredict;
         r_target[wb_rob_id]  <= wb_target;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rob_commit_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_commit_unit
// Purpose  : Directed self-checking bench for rob_commit_unit (ROB_WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rob_commit_unit;

   localparam int ROB_WIDTH = 4;

   logic                 clk_in = 1'b0;
   logic                 rst_n_in;
   logic                 rdy_in;
   logic                 issue_valid;
   logic [4:0]           issue_rd;
   logic [ROB_WIDTH-1:0] issue_rob_id;
   logic                 rob_full;
   logic                 wb_valid;
   logic [ROB_WIDTH-1:0] wb_rob_id;
   logic [31:0]          wb_val;
   logic                 wb_mispredict;
   logic [31:0]          wb_target;
   logic [ROB_WIDTH-1:0] search_rob_id_1;
   logic                 search_ready_1;
   logic [31:0]          search_val_1;
   logic [ROB_WIDTH-1:0] search_rob_id_2;
   logic                 search_ready_2;
   logic [31:0]          search_val_2;
   logic                 commit_ready;
   logic [4:0]           commit_reg_id;
   logic [31:0]          commit_val;
   logic [ROB_WIDTH-1:0] commit_rob_id;
   logic                 clear;
   logic [31:0]          clear_pc;

   int checks = 0;
   int errors = 0;

   always #5 clk_in = ~clk_in;

   rob_commit_unit #(.ROB_WIDTH(ROB_WIDTH)) dut (
      .clk_in          (clk_in),
      .rst_n_in        (rst_n_in),
      .rdy_in          (rdy_in),
      .issue_valid     (issue_valid),
      .issue_rd        (issue_rd),
      .issue_rob_id    (issue_rob_id),
      .rob_full        (rob_full),
      .wb_valid        (wb_valid),
      .wb_rob_id       (wb_rob_id),
      .wb_val          (wb_val),
      .wb_mispredict   (wb_mispredict),
      .wb_target       (wb_target),
      .search_rob_id_1 (search_rob_id_1),
      .search_ready_1  (search_ready_1),
      .search_val_1    (search_val_1),
      .search_rob_id_2 (search_rob_id_2),
      .search_ready_2  (search_ready_2),
      .search_val_2    (search_val_2),
      .commit_ready    (commit_ready),
      .commit_reg_id   (commit_reg_id),
      .commit_val      (commit_val),
      .commit_rob_id   (commit_rob_id),
      .clear           (clear),
      .clear_pc        (clear_pc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_issue(input logic [4:0] rd);
      issue_valid = 1'b1;
      issue_rd    = rd;
   endtask

   task automatic drive_wb(input logic [ROB_WIDTH-1:0] tag, input logic [31:0] val,
                           input logic mis, input logic [31:0] tgt);
      wb_valid      = 1'b1;
      wb_rob_id     = tag;
      wb_val        = val;
      wb_mispredict = mis;
      wb_target     = tgt;
   endtask

   // Advance one clock; inputs are released 1 ns after the edge.
   task automatic cyc();
      @(posedge clk_in);
      #1;
      issue_valid   = 1'b0;
      wb_valid      = 1'b0;
      wb_mispredict = 1'b0;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst_n_in = 1'b1; rdy_in = 1'b1;
      issue_valid = 1'b0; issue_rd = 5'd0;
      wb_valid = 1'b0; wb_rob_id = '0; wb_val = 32'd0; wb_mispredict = 1'b0; wb_target = 32'd0;
      search_rob_id_1 = '0; search_rob_id_2 = '0;

      // ---------------- reset ----------------
      #2 rst_n_in = 1'b0;
      #2;
      chk("rst_commit_ready", commit_ready, 0);
      chk("rst_rob_full", rob_full, 0);
      chk("rst_issue_rob_id", issue_rob_id, 0);
      chk("rst_clear", clear, 0);
      chk("rst_clear_pc", clear_pc, 0);
      chk("rst_search_ready", search_ready_1, 0);
      repeat (2) @(posedge clk_in);
      @(negedge clk_in) rst_n_in = 1'b1;
      cyc();

      // ---------------- out-of-order writeback ----------------
      drive_issue(5); cyc();
      drive_issue(6); cyc();
      drive_issue(7); cyc();
      settle();
      chk("ooo_tail", issue_rob_id, 3);
      chk("ooo_no_commit", commit_ready, 0);
      drive_wb(2, 32'h33, 0, 0); settle();
      chk("ooo_wb2_no_commit", commit_ready, 0);
      cyc();
      drive_wb(1, 32'h22, 0, 0); cyc();
      drive_wb(0, 32'h11, 0, 0); settle();
      chk("ooo_wb_head_same_cycle", commit_ready, 0);
      cyc(); settle();
      chk("ooo_c0_ready", commit_ready, 1);
      chk("ooo_c0_rd", commit_reg_id, 5);
      chk("ooo_c0_val", commit_val, 32'h11);
      chk("ooo_c0_id", commit_rob_id, 0);
      cyc(); settle();
      chk("ooo_c1_ready", commit_ready, 1);
      chk("ooo_c1_rd", commit_reg_id, 6);
      chk("ooo_c1_val", commit_val, 32'h22);
      chk("ooo_c1_id", commit_rob_id, 1);
      cyc(); settle();
      chk("ooo_c2_ready", commit_ready, 1);
      chk("ooo_c2_rd", commit_reg_id, 7);
      chk("ooo_c2_val", commit_val, 32'h33);
      chk("ooo_c2_id", commit_rob_id, 2);
      cyc(); settle();
      chk("empty_commit_ready", commit_ready, 0);
      chk("empty_reg_id", commit_reg_id, 0);
      chk("empty_rob_id", commit_rob_id, 0);

      // ---------------- search ----------------
      drive_issue(8); cyc();
      drive_issue(9); cyc();
      drive_wb(3, 32'hABCD, 0, 0); cyc();
      search_rob_id_1 = 3; search_rob_id_2 = 4; settle();
      chk("srch1_ready", search_ready_1, 1);
      chk("srch1_val", search_val_1, 32'hABCD);
      chk("srch2_ready", search_ready_2, 0);
      chk("srch2_val", search_val_2, 0);
      chk("srch_commit_id", commit_rob_id, 3);
      cyc(); settle();
      chk("srch_after_commit", search_ready_1, 0);
      drive_wb(4, 32'h44, 0, 0); cyc(); settle();
      chk("c4_ready", commit_ready, 1);
      chk("c4_val", commit_val, 32'h44);
      cyc();

      // ---------------- mispredict ----------------
      drive_issue(1); cyc();
      drive_issue(2); cyc();
      drive_issue(3); cyc();
      drive_issue(4); cyc();
      drive_wb(6, 32'h66, 1, 32'h100); cyc();
      drive_wb(5, 32'h55, 0, 0); cyc(); settle();
      chk("mp_c5_ready", commit_ready, 1);
      chk("mp_c5_id", commit_rob_id, 5);
      cyc(); settle();
      chk("mp_c6_ready", commit_ready, 1);
      chk("mp_c6_id", commit_rob_id, 6);
      chk("mp_c6_noclear", clear, 0);
      cyc();
      drive_issue(3); settle();
      chk("mp_clear", clear, 1);
      chk("mp_clear_pc", clear_pc, 32'h100);
      chk("mp_clear_commit", commit_ready, 0);
      chk("mp_clear_tail", issue_rob_id, 0);
      cyc(); settle();
      chk("mp_clear_pulse", clear, 0);
      chk("mp_issue_ignored", issue_rob_id, 0);
      chk("mp_empty", commit_rob_id, 0);
      search_rob_id_1 = 7; settle();
      chk("mp_srch_flushed", search_ready_1, 0);

      // ---------------- fill / full ----------------
      for (int i = 0; i < 15; i++) begin
         drive_issue(5'(i + 1)); cyc();
      end
      settle();
      chk("fill15_not_full", rob_full, 0);
      drive_issue(16); cyc(); settle();
      chk("fill16_full", rob_full, 1);
      chk("fill16_tail", issue_rob_id, 0);
      drive_issue(17); cyc(); settle();
      chk("full_issue_ignored", issue_rob_id, 0);
      chk("full_still_full", rob_full, 1);
      drive_wb(0, 32'h77, 0, 0); cyc();
      drive_issue(18); settle();
      chk("full_commit_ready", commit_ready, 1);
      chk("full_during_commit", rob_full, 1);
      cyc(); settle();
      chk("full_freed", rob_full, 0);
      chk("full_no_issue_on_commit", issue_rob_id, 0);

      // ---------------- pause ----------------
      drive_wb(1, 32'h81, 0, 0); cyc();
      rdy_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive_wb(2, 32'h82, 0, 0); drive_issue(4); settle();
         chk("pause_commit_ready", commit_ready, 0);
         cyc();
      end
      rdy_in = 1'b1; settle();
      chk("pause_resume_commit", commit_ready, 1);
      chk("pause_resume_id", commit_rob_id, 1);
      chk("pause_resume_val", commit_val, 32'h81);
      chk("pause_issue_ignored", issue_rob_id, 0);
      cyc(); settle();
      chk("pause_wb_ignored", commit_ready, 0);

      // ---------------- drain and wrap ----------------
      for (int t = 2; t < 16; t++) begin
         drive_wb(ROB_WIDTH'(t), 32'h100 + 32'(t), 0, 0); cyc(); settle();
         chk("drain_id", commit_rob_id, 32'(t));
         chk("drain_val", commit_val, 32'h100 + 32'(t));
         cyc();
      end
      settle();
      chk("wrap_empty_commit", commit_ready, 0);
      chk("wrap_tail", issue_rob_id, 0);
      drive_issue(10); cyc();
      drive_wb(0, 32'hCAFE, 0, 0); cyc(); settle();
      chk("wrap_head_id", commit_rob_id, 0);
      chk("wrap_head_rd", commit_reg_id, 10);
      chk("wrap_head_val", commit_val, 32'hCAFE);
      cyc();

      // ---------------- mid-run async reset ----------------
      for (int i = 0; i < 5; i++) begin
         drive_issue(5'(20 + i)); cyc();
      end
      drive_wb(1, 32'h99, 0, 0); cyc();
      search_rob_id_1 = 1; settle();
      chk("pre_rst_commit", commit_ready, 1);
      chk("pre_rst_search", search_ready_1, 1);
      #3 rst_n_in = 1'b0;
      #1;
      chk("async_rst_commit", commit_ready, 0);
      chk("async_rst_search", search_ready_1, 0);
      chk("async_rst_tail", issue_rob_id, 0);
      chk("async_rst_val", commit_val, 0);
      @(negedge clk_in) rst_n_in = 1'b1;
      cyc(); settle();
      chk("post_rst_tail", issue_rob_id, 0);
      chk("post_rst_full", rob_full, 0);
      drive_issue(3); cyc(); settle();
      chk("post_rst_issue", issue_rob_id, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
